pio_in_debounce: RTL and testbench
==================================

// Module: pio_in_debounce
// PURPOSE
//   Conditions WIDTH asynchronous raw inputs (board switches, camera status lines) into a clean, glitch-free word.
//   Output drives in_port of a 4-bit Avalon-MM input PIO slave; the PIO registers it into readdata.
//   Per bit: SYNC_STAGES-flop synchronizer, then a debounce counter; a level commits only after staying stable.
// PARAMETERS
//   WIDTH            4      number of independent input bits
//   SYNC_STAGES      2      synchronizer depth, legal 2..4
//   DEBOUNCE_CYCLES  50000  consecutive clk cycles a new level must hold before commit (1 ms @ 50 MHz); legal >= 1
//   RESET_VALUE      '0     WIDTH-bit value loaded into synchronizer flops and deb_out on reset
// PORTS
//   clk           in   1      system clock, all logic on rising edge
//   reset_n       in   1      asynchronous, active-low reset
//   raw_in        in   WIDTH  asynchronous raw inputs, no timing relation to clk
//   deb_out       out  WIDTH  debounced, registered word; connects to PIO in_port
//   change_pulse  out  WIDTH  [PIO_DEB_CHANGE_EN only] one-cycle strobe per bit on commit
// BEHAVIOUR
//   Reset (async assert, sync to clk on release):
//     - sync chain = RESET_VALUE, deb_out = RESET_VALUE, all counters = 0, change_pulse = 0.
//   Synchronizer: raw_in[i] -> SYNC_STAGES flops -> s[i]; no logic between stages.
//   Per-bit FSM, 2 states, counter cnt[i] width $clog2(DEBOUNCE_CYCLES+1):
//     STABLE : s[i]==deb_out[i]; cnt=0. If s[i]!=deb_out[i] -> COUNTING.
//       - If DEBOUNCE_CYCLES==1, commit on that same edge instead.
//     COUNTING: each edge where s[i]!=deb_out[i]:
//       - cnt < DEBOUNCE_CYCLES-1 : cnt++.
//       - cnt == DEBOUNCE_CYCLES-1 : deb_out[i]<=s[i], cnt<=0, -> STABLE (commit).
//       - s[i]==deb_out[i] on any edge (glitch ended) : cnt<=0, -> STABLE, no commit.
//   Latency: deb_out changes after exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges.
//     - Count starts at the first edge sampling the new raw level, when raw is held throughout.
//   Glitch rule: any excursion shorter than DEBOUNCE_CYCLES synchronized cycles never reaches deb_out.
//   Bits are fully independent: simultaneous changes on several bits commit on the same edge.
//   Counter never wraps: it is cleared on commit or on return to stable, and cannot exceed DEBOUNCE_CYCLES-1.
//   Reset mid-count: count discarded; deb_out returns to RESET_VALUE immediately.
//   deb_out is glitch-free (flop output); safe to cross into any consumer on clk.
// CONFIGURATION
//   `define PIO_DEB_CHANGE_EN:
//     - adds output change_pulse[WIDTH].
//     - change_pulse[i] is high exactly one cycle, on the cycle deb_out[i] takes its new value.
//     - Intended for PIO edge-capture/IRQ.
//   Undefined: port absent, no extra flops; deb_out behaviour identical.
// STRUCTURE
//   Package pio_deb_pkg:
//     - typedef enum logic {ST_STABLE, ST_COUNTING} deb_state_t.
//     - function cnt_width(n) returning $clog2(n+1).
//   Sub-module pio_deb_bit: one bit (sync chain + FSM + counter); top instantiates WIDTH copies in a generate loop.
//   Elaboration-time check: SYNC_STAGES in 2..4 and DEBOUNCE_CYCLES>=1, else $error.
// TESTING (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=4)
//   1. Reset, raw_in=4'b0000: deb_out=0 throughout reset. raw_in->4'b0101 held -> deb_out=4'b0101 exactly 6 edges later.
//   2. Glitch: raw_in[0] 0->1 for 3 cycles then back to 0 -> deb_out[0] stays 0; repeat with 4 cycles -> commits to 1.
//   3. Bounce: raw_in[2] toggles 1,0,1,0,1 every cycle then holds 1 -> deb_out[2]=1 six edges after the final 0->1.
//   4. Simultaneous: raw_in 0000->1111 on one edge -> all four bits commit on the same edge.
//   5. Reset mid-count: raw_in[3]=1 for 4 cycles, assert reset_n=0 async -> deb_out=RESET_VALUE at once; after release counting restarts from 0.
//   6. PIO_DEB_CHANGE_EN defined: each commit in tests 1-4 -> change_pulse[i]=1 for exactly one cycle, aligned with deb_out update; no pulse on glitches.

Source files
------------

// File: rtl/pio_deb_pkg.sv
// Shared types and sizing helpers for the PIO input debouncer.
package pio_deb_pkg;

    typedef enum logic {ST_STABLE, ST_COUNTING} deb_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pio_deb_bit.sv
// One debounced input bit: synchronizer chain, two-state FSM and hold counter.
// With PIO_DEB_CHANGE_EN defined, a registered one-cycle change_pulse is added.
module pio_deb_bit
    import pio_deb_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic deb
`ifdef PIO_DEB_CHANGE_EN
    ,
    output logic change_pulse
`endif
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             ONE_SHOT = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   deb_q;
    deb_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   differs;
    logic                   commit;

    assign s   = sync_q[SYNC_STAGES-1];
    assign deb = deb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
            deb_q  <= RESET_BIT;
            state  <= ST_STABLE;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            deb_q  <= commit ? s : deb_q;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // The edge that first sees the new level counts as hold cycle 1, so the
    // commit lands SYNC_STAGES+DEBOUNCE_CYCLES edges after the raw change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_STABLE: begin
                cnt_nxt = '0;
                if (differs && !commit) begin
                    state_nxt = ST_COUNTING;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_COUNTING: begin
                if (!differs || commit) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        differs = s ^ deb_q;
        commit  = differs && ((state == ST_STABLE) ? ONE_SHOT : (cnt == CNT_LAST));
    end

`ifdef PIO_DEB_CHANGE_EN
    logic pulse_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pulse_q <= 1'b0;
        else          pulse_q <= commit;
    end

    assign change_pulse = pulse_q;
`else
`endif

endmodule

// File: rtl/pio_in_debounce.sv
// WIDTH independent synchronize-and-debounce lanes feeding a PIO in_port.
// Optional change_pulse output is enabled by defining PIO_DEB_CHANGE_EN.
module pio_in_debounce
    import pio_deb_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] deb_out
`ifdef PIO_DEB_CHANGE_EN
    ,
    output logic [WIDTH-1:0] change_pulse
`endif
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("pio_in_debounce: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef PIO_DEB_CHANGE_EN
        pio_deb_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_bit (
            .clk          (clk),
            .reset_n      (reset_n),
            .raw          (raw_in[i]),
            .deb          (deb_out[i]),
            .change_pulse (change_pulse[i])
        );
`else
        pio_deb_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw_in[i]),
            .deb     (deb_out[i])
        );
`endif
    end

endmodule

// File: tb/tb_pio_in_debounce.sv
// Directed bench for pio_in_debounce with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_pio_in_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] raw_in;
    logic [3:0] deb_out;
`ifdef PIO_DEB_CHANGE_EN
    logic [3:0] change_pulse;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pio_in_debounce #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (4'b0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_in       (raw_in),
        .deb_out      (deb_out)
`ifdef PIO_DEB_CHANGE_EN
        ,
        .change_pulse (change_pulse)
`endif
    );

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, act, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input logic [3:0] exp);
`ifdef PIO_DEB_CHANGE_EN
        chk({tag, "_pulse"}, change_pulse, exp);
`endif
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold_quiet(input string tag, input int n, input logic [3:0] v);
        for (int k = 0; k < n; k++) begin
            tick();
            chk(tag, deb_out, v);
            chk_pulse(tag, 4'b0000);
        end
    endtask

    // Raw already changed just before this call; commit expected on edge 6.
    task automatic expect_commit(input string tag, input logic [3:0] old_v,
                                 input logic [3:0] new_v, input logic [3:0] mask);
        hold_quiet({tag, "_hold"}, 5, old_v);
        tick();
        chk({tag, "_commit"}, deb_out, new_v);
        chk_pulse({tag, "_commit"}, mask);
        tick();
        chk({tag, "_after"}, deb_out, new_v);
        chk_pulse({tag, "_after"}, 4'b0000);
    endtask

    initial begin
        reset_n = 1'b0;
        raw_in  = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", deb_out, 4'b0000);
            chk_pulse("rst_hold", 4'b0000);
        end
        reset_n = 1'b1;
        hold_quiet("rst_idle", 3, 4'b0000);

        // 1. basic latency
        raw_in = 4'b0101;
        expect_commit("t1", 4'b0000, 4'b0101, 4'b0101);
        raw_in = 4'b0000;
        expect_commit("t1_back", 4'b0101, 4'b0000, 4'b0101);

        // 2. 3-cycle glitch is rejected
        raw_in = 4'b0001;
        hold_quiet("t2_g3_hi", 3, 4'b0000);
        raw_in = 4'b0000;
        hold_quiet("t2_g3_lo", 6, 4'b0000);

        // 2b. 4-cycle excursion commits, then its return commits back
        raw_in = 4'b0001;
        hold_quiet("t2_g4_hi", 4, 4'b0000);
        raw_in = 4'b0000;
        hold_quiet("t2_g4_lo", 1, 4'b0000);
        tick();
        chk("t2_g4_commit", deb_out, 4'b0001);
        chk_pulse("t2_g4_commit", 4'b0001);
        hold_quiet("t2_g4_held", 3, 4'b0001);
        tick();
        chk("t2_g4_return", deb_out, 4'b0000);
        chk_pulse("t2_g4_return", 4'b0001);
        hold_quiet("t2_g4_idle", 2, 4'b0000);

        // 3. bounce on bit 2 then hold high
        raw_in = 4'b0100;
        hold_quiet("t3_b1", 1, 4'b0000);
        raw_in = 4'b0000;
        hold_quiet("t3_b0", 1, 4'b0000);
        raw_in = 4'b0100;
        hold_quiet("t3_b1", 1, 4'b0000);
        raw_in = 4'b0000;
        hold_quiet("t3_b0", 1, 4'b0000);
        raw_in = 4'b0100;
        expect_commit("t3", 4'b0000, 4'b0100, 4'b0100);
        raw_in = 4'b0000;
        expect_commit("t3_back", 4'b0100, 4'b0000, 4'b0100);

        // 4. simultaneous change on all bits
        raw_in = 4'b1111;
        expect_commit("t4", 4'b0000, 4'b1111, 4'b1111);
        raw_in = 4'b0111;
        expect_commit("t4_b3", 4'b1111, 4'b0111, 4'b1000);

        // 5. reset in the middle of a count on bit 3
        raw_in = 4'b1111;
        hold_quiet("t5_count", 4, 4'b0111);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async", deb_out, 4'b0000);
        chk_pulse("t5_async", 4'b0000);
        @(negedge clk);
        chk("t5_in_rst", deb_out, 4'b0000);
        reset_n = 1'b1;
        expect_commit("t5_restart", 4'b0000, 4'b1111, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
